register_file_param: RTL and testbench

Parametrised two-read/one-write register file for the highRISC datapath, the successor to the fixed 64 x 16 register file. It adds asynchronous reset, byte-enabled writes, optional hardwired-zero register 0 and optional write-to-read bypass. A sequenced bulk-clear engine zeroes every register under a request/busy/done handshake. It sits between decode (read addresses) and writeback (write port).

---
 rtl/register_file_param.sv | 133 +++++++++++++
 tb/tb_register_file_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// Two-read/one-write register file with byte-enabled writes, optional zero register,
// optional write-to-read bypass and a sequenced bulk-clear engine.
module register_file_param #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrWidth = 6,
    parameter bit          ZeroReg   = 1'b1,
    parameter bit          Bypass    = 1'b1
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic [AddrWidth-1:0]     AddressA,
    output logic [DataWidth-1:0]     ReadDataA,
    input  logic [AddrWidth-1:0]     AddressB,
    output logic [DataWidth-1:0]     ReadDataB,
    input  logic [AddrWidth-1:0]     WriteAddress,
    input  logic [DataWidth-1:0]     WriteData,
    input  logic                     WriteEnable,
    input  logic [DataWidth/8-1:0]   ByteEnable,
    input  logic                     ClearRequest,
    output logic                     ClearBusy,
    output logic                     ClearDone
);

    localparam int unsigned Depth     = 2 ** AddrWidth;
    localparam int unsigned ByteCount = DataWidth / 8;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Clear = 2'd1,
        Done  = 2'd2
    } clearState_t;

    clearState_t          state;
    logic [AddrWidth-1:0] clearCount;
    logic [DataWidth-1:0] regs [Depth];

    logic                 writeLive;
    logic                 writeAccept;
    logic [DataWidth-1:0] writeMerged;

    // Enabled bytes take the new data, the rest keep the stored value.
    function automatic logic [DataWidth-1:0] mergeBytes(
        input logic [DataWidth-1:0]   stored,
        input logic [DataWidth-1:0]   data,
        input logic [ByteCount-1:0]   enables
    );
        logic [DataWidth-1:0] merged;
        merged = stored;
        for (int i = 0; i < int'(ByteCount); i++) begin
            if (enables[i]) begin
                merged[8*i +: 8] = data[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign writeLive   = WriteEnable && !ClearBusy;
    assign writeAccept = writeLive && !(ZeroReg && (WriteAddress == '0));
    assign writeMerged = mergeBytes(regs[WriteAddress], WriteData, ByteEnable);

    // Read port A: storage, then bypass, then the hardwired zero register wins.
    always_comb begin
        ReadDataA = regs[AddressA];
        if (Bypass && writeLive && (WriteAddress == AddressA)) begin
            ReadDataA = writeMerged;
        end
        if (ZeroReg && (AddressA == '0)) begin
            ReadDataA = '0;
        end
    end

    always_comb begin
        ReadDataB = regs[AddressB];
        if (Bypass && writeLive && (WriteAddress == AddressB)) begin
            ReadDataB = writeMerged;
        end
        if (ZeroReg && (AddressB == '0)) begin
            ReadDataB = '0;
        end
    end

    // Storage array; the clear engine owns it whenever it is sweeping.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                regs[i] <= '0;
            end
        end else if (state == Clear) begin
            regs[clearCount] <= '0;
        end else if (writeAccept) begin
            regs[WriteAddress] <= writeMerged;
        end
    end

    // Clear sequencer: terminal compare on the last address avoids a wrap restart.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= Idle;
            clearCount <= '0;
            ClearBusy  <= 1'b0;
            ClearDone  <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    ClearDone <= 1'b0;
                    if (ClearRequest) begin
                        state      <= Clear;
                        clearCount <= '0;
                        ClearBusy  <= 1'b1;
                    end
                end
                Clear: begin
                    clearCount <= clearCount + AddrWidth'(1);
                    if (clearCount == AddrWidth'(Depth - 1)) begin
                        state     <= Done;
                        ClearDone <= 1'b1;
                    end
                end
                Done: begin
                    state     <= Idle;
                    ClearBusy <= 1'b0;
                    ClearDone <= 1'b0;
                end
                default: begin
                    state     <= Idle;
                    ClearBusy <= 1'b0;
                    ClearDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: reset, byte writes, bypass, zero register,
// bulk clear timing, reset mid-clear and write-with-clear-request.
module tb_register_file_param;

    logic        Clock;
    logic        nReset;
    logic [5:0]  AddressA;
    logic [15:0] ReadDataA;
    logic [5:0]  AddressB;
    logic [15:0] ReadDataB;
    logic [5:0]  WriteAddress;
    logic [15:0] WriteData;
    logic        WriteEnable;
    logic [1:0]  ByteEnable;
    logic        ClearRequest;
    logic        ClearBusy;
    logic        ClearDone;

    int errors = 0;
    int checks = 0;

    register_file_param #(
        .DataWidth(16),
        .AddrWidth(6),
        .ZeroReg(1'b1),
        .Bypass(1'b1)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .AddressA(AddressA),
        .ReadDataA(ReadDataA),
        .AddressB(AddressB),
        .ReadDataB(ReadDataB),
        .WriteAddress(WriteAddress),
        .WriteData(WriteData),
        .WriteEnable(WriteEnable),
        .ByteEnable(ByteEnable),
        .ClearRequest(ClearRequest),
        .ClearBusy(ClearBusy),
        .ClearDone(ClearDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int busyCount;
        int doneCount;
        int doneAt;
        int zeroBad;

        nReset       = 1'b0;
        AddressA     = 6'd5;
        AddressB     = 6'd63;
        WriteAddress = '0;
        WriteData    = '0;
        WriteEnable  = 1'b0;
        ByteEnable   = 2'b00;
        ClearRequest = 1'b0;
        #3;
        check("reset_rda", ReadDataA, 16'h0000);
        check("reset_rdb", ReadDataB, 16'h0000);
        check("reset_busy", ClearBusy, 1'b0);
        check("reset_done", ClearDone, 1'b0);
        #10;
        nReset = 1'b1;

        // Byte-enabled writes
        WriteEnable = 1'b1; WriteAddress = 6'd7; WriteData = 16'hABCD; ByteEnable = 2'b11;
        tick();
        WriteData = 16'h1234; ByteEnable = 2'b01;
        tick();
        WriteEnable = 1'b0; AddressA = 6'd7;
        #1;
        check("byte_write", ReadDataA, 16'hAB34);

        // Same-cycle bypass on both ports
        WriteEnable = 1'b1; WriteAddress = 6'd9; WriteData = 16'h5A5A; ByteEnable = 2'b11;
        AddressA = 6'd9; AddressB = 6'd9;
        #1;
        check("bypass_a", ReadDataA, 16'h5A5A);
        check("bypass_b", ReadDataB, 16'h5A5A);
        tick();
        WriteEnable = 1'b0;
        #1;
        check("bypass_stored", ReadDataA, 16'h5A5A);

        // Bypass of a partial write shows the merged value
        WriteEnable = 1'b1; WriteAddress = 6'd7; WriteData = 16'h9900; ByteEnable = 2'b10;
        AddressA = 6'd7;
        #1;
        check("bypass_merge", ReadDataA, 16'h9934);
        tick();
        WriteEnable = 1'b0;
        #1;
        check("merge_stored", ReadDataA, 16'h9934);

        // Byte enable all zero is a no-op
        WriteEnable = 1'b1; WriteData = 16'h1111; ByteEnable = 2'b00;
        tick();
        WriteEnable = 1'b0;
        #1;
        check("be_zero_noop", ReadDataA, 16'h9934);

        // Zero register
        WriteEnable = 1'b1; WriteAddress = 6'd0; WriteData = 16'hFFFF; ByteEnable = 2'b11;
        AddressA = 6'd0;
        #1;
        check("zero_bypass", ReadDataA, 16'h0000);
        tick();
        WriteEnable = 1'b0;
        #1;
        check("zero_stored", ReadDataA, 16'h0000);

        // Fill 1..63 with their index
        for (int i = 1; i < 64; i++) begin
            WriteEnable = 1'b1; WriteAddress = 6'(i); WriteData = 16'(i); ByteEnable = 2'b11;
            tick();
        end
        WriteEnable = 1'b0;
        AddressA = 6'd63; AddressB = 6'd3;
        #1;
        check("fill_63", ReadDataA, 16'h003F);
        check("fill_3", ReadDataB, 16'h0003);

        // Bulk clear: edge T samples the request
        ClearRequest = 1'b1;
        tick();
        ClearRequest = 1'b0;
        busyCount = ClearBusy ? 1 : 0;
        doneCount = 0;
        doneAt    = -1;
        check("clear_busy_at_T", ClearBusy, 1'b1);
        // Write during busy: no bypass, dropped
        WriteEnable = 1'b1; WriteAddress = 6'd3; WriteData = 16'h1111; ByteEnable = 2'b11;
        AddressA = 6'd3;
        #1;
        check("busy_no_bypass", ReadDataA, 16'h0003);
        for (int k = 1; k <= 69; k++) begin
            tick();
            if (k == 1) begin
                WriteEnable = 1'b0;
                check("busy_write_lost", ReadDataA, 16'h0003);
            end
            if (ClearBusy) busyCount++;
            if (ClearDone) begin
                doneCount++;
                doneAt = k;
            end
        end
        check("clear_busy_cycles", busyCount, 65);
        check("clear_done_count", doneCount, 1);
        check("clear_done_cycle", doneAt, 64);
        zeroBad = 0;
        for (int a = 0; a < 64; a++) begin
            AddressA = 6'(a);
            #1;
            if (ReadDataA !== 16'h0000) zeroBad++;
        end
        check("clear_all_zero", zeroBad, 0);

        // Reset mid-clear
        WriteEnable = 1'b1; WriteAddress = 6'd40; WriteData = 16'h4040; ByteEnable = 2'b11;
        tick();
        WriteAddress = 6'd62; WriteData = 16'h6262;
        tick();
        WriteEnable = 1'b0;
        ClearRequest = 1'b1;
        tick();
        ClearRequest = 1'b0;
        AddressA = 6'd40; AddressB = 6'd62;
        for (int k = 1; k <= 20; k++) tick();
        #1;
        check("midclear_pre_a", ReadDataA, 16'h4040);
        nReset = 1'b0;
        #1;
        check("midclear_busy", ClearBusy, 1'b0);
        check("midclear_rda", ReadDataA, 16'h0000);
        check("midclear_rdb", ReadDataB, 16'h0000);
        #3;
        nReset = 1'b1;
        doneCount = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (ClearDone) doneCount++;
        end
        check("midclear_no_done", doneCount, 0);

        // Write together with a clear request in idle
        WriteEnable = 1'b1; WriteAddress = 6'd10; WriteData = 16'h00FF; ByteEnable = 2'b11;
        ClearRequest = 1'b1;
        AddressA = 6'd10;
        tick();
        WriteEnable = 1'b0; ClearRequest = 1'b0;
        check("simul_after_T", ReadDataA, 16'h00FF);
        for (int k = 1; k <= 10; k++) tick();
        check("simul_T10", ReadDataA, 16'h00FF);
        tick();
        check("simul_T11", ReadDataA, 16'h0000);
        for (int k = 0; k < 70 && ClearBusy; k++) tick();
        check("simul_idle", ClearBusy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
